// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - one-hot command decoder and single/multi-cycle ALU op sequencer
module alu_ctrl_sequencer #(
    parameter int               CTRL_W  = 8,
    parameter int               ACTRL_W = 4,
    parameter logic [CTRL_W-1:0] MC_MASK = CTRL_W'(8'b0011_0000),
    parameter int               MC_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [CTRL_W-1:0]  cmd,
    output logic               cmd_ready,
    output logic [ACTRL_W-1:0] alu_ctrl,
    output logic               alu_start,
    output logic               alu_busy,
    output logic               done,
    output logic               err,
    output logic               err_sticky,
    input  logic               clear_err,
    input  logic               flush
);

    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               mc_q;
    logic               err_q;
    logic               sticky_q;
    logic [ACTRL_W-1:0] ctrl_q;

    logic               legal_c;
    logic               mc_c;
    logic [ACTRL_W-1:0] code_c;
    logic               accept;

    // MSB of cmd is op 0, so the code counts down from the top bit
    always_comb begin
        legal_c = (cmd != '0) && ((cmd & (cmd - CTRL_W'(1))) == '0);
        code_c  = '0;
        mc_c    = 1'b0;
        for (int i = 0; i < CTRL_W; i++) begin
            if (cmd[i]) begin
                code_c = ACTRL_W'(CTRL_W - 1 - i);
                mc_c   = MC_MASK[i];
            end
        end
    end

    assign accept = cmd_valid && (state == IDLE) && !flush;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && legal_c) state_n = ISSUE;
            ISSUE:   state_n = mc_q ? WAIT : DONE;
            WAIT:    if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mc_q     <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state <= state_n;
            err_q <= accept && !legal_c;
            // a new illegal command outranks a simultaneous clear request
            if (accept && !legal_c)
                sticky_q <= 1'b1;
            else if (clear_err)
                sticky_q <= 1'b0;
            if (accept && legal_c) begin
                ctrl_q <= code_c;
                mc_q   <= mc_c;
            end
            if (flush)
                cnt <= '0;
            else if (state == ISSUE)
                cnt <= CNT_W'(MC_LAT - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign alu_start  = (state == ISSUE);
    assign alu_busy   = (state == ISSUE) || (state == WAIT);
    assign done       = (state == DONE);
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign alu_ctrl   = ctrl_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - randomized self-checking bench for alu_ctrl_sequencer
module tb_alu_ctrl_sequencer;

    localparam int         MC_LAT  = 4;
    localparam logic [7:0] MC_MASK = 8'b0011_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       cmd_ready;
    logic [3:0] alu_ctrl;
    logic       alu_start;
    logic       alu_busy;
    logic       done;
    logic       err;
    logic       err_sticky;
    logic       clear_err;
    logic       flush;

    int n_checks = 0;
    int n_errors = 0;

    int exp_ctrl   = 0;
    int exp_sticky = 0;

    alu_ctrl_sequencer #(
        .CTRL_W (8),
        .ACTRL_W(4),
        .MC_MASK(MC_MASK),
        .MC_LAT (MC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .alu_ctrl  (alu_ctrl),
        .alu_start (alu_start),
        .alu_busy  (alu_busy),
        .done      (done),
        .err       (err),
        .err_sticky(err_sticky),
        .clear_err (clear_err),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] c);
        return $countones(c) == 1;
    endfunction

    function automatic int code_of(input logic [7:0] c);
        return 7 - $clog2(c);
    endfunction

    // cycle in which done is expected, counting the accept cycle as 0
    function automatic int done_cycle(input logic [7:0] c);
        return ((c & MC_MASK) != 0) ? MC_LAT + 2 : 2;
    endfunction

    task automatic run_cmd(input logic [7:0] c, input bit clr, input int flush_cyc);
        int lat;
        int last;
        bit idle;
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        clear_err = clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clear_err = 1'b0;
        cmd       = 8'($urandom);
        if (!is_legal(c)) begin
            exp_sticky = 1;
            @(negedge clk);
            check("err_pulse", err, 1);
            check("err_sticky_set", err_sticky, exp_sticky);
            check("err_no_start", alu_start, 0);
            check("err_ctrl_kept", alu_ctrl, exp_ctrl);
            check("err_ready", cmd_ready, 1);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            return;
        end
        exp_ctrl = code_of(c);
        if (clr) exp_sticky = 0;
        lat  = done_cycle(c);
        last = lat + 1;
        if (flush_cyc != 0 && flush_cyc + 1 < last) last = flush_cyc + 1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            idle = (flush_cyc != 0) && (cyc > flush_cyc);
            @(negedge clk);
            check("alu_start", alu_start, int'(!idle && cyc == 1));
            check("alu_busy", alu_busy, int'(!idle && cyc < lat));
            check("done", done, int'(!idle && cyc == lat));
            check("cmd_ready", cmd_ready, int'(idle || cyc > lat));
            check("alu_ctrl", alu_ctrl, exp_ctrl);
            check("err_quiet", err, 0);
            check("err_sticky", err_sticky, exp_sticky);
            flush = (cyc == flush_cyc);
        end
        flush = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int         fc;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 8'h00;
        clear_err = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", alu_ctrl, 0);
        check("rst_start", alu_start, 0);
        check("rst_busy", alu_busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sticky", err_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);

        run_cmd(8'b1000_0000, 1'b0, 0);
        run_cmd(8'b0100_0000, 1'b0, 0);
        run_cmd(8'b0000_0001, 1'b0, 0);
        run_cmd(8'b0001_0000, 1'b0, 0);
        run_cmd(8'b0000_0000, 1'b0, 0);
        run_cmd(8'b1100_0000, 1'b1, 0);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err  = 1'b0;
        exp_sticky = 0;
        check("clear_err", err_sticky, exp_sticky);

        run_cmd(8'b0010_0000, 1'b0, 3);
        run_cmd(8'b0000_1000, 1'b0, 0);

        @(negedge clk);
        cmd       = 8'b1000_0000;
        cmd_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", cmd_ready, 1);
        check("flush_idle_start", alu_start, 0);
        check("flush_idle_err", err, 0);
        check("flush_idle_ctrl", alu_ctrl, exp_ctrl);
        cmd_valid = 1'b0;
        flush     = 1'b0;

        @(negedge clk);
        cmd       = 8'b0001_0000;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", alu_busy, 1);
        rst_n = 1'b0;
        #1;
        exp_ctrl   = 0;
        exp_sticky = 0;
        check("midrst_ctrl", alu_ctrl, exp_ctrl);
        check("midrst_start", alu_start, 0);
        check("midrst_busy", alu_busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_sticky", err_sticky, exp_sticky);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(8'b0000_0010, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7)
                c = 8'(1 << $urandom_range(0, 7));
            else
                c = 8'($urandom);
            fc = 0;
            if (is_legal(c) && $urandom_range(0, 4) == 0)
                fc = $urandom_range(1, done_cycle(c));
            run_cmd(c, ($urandom_range(0, 3) == 0), fc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
Parametrised, registered successor to the one-hot ALU control decoder. It accepts a one-hot operation command over a valid/ready handshake and decodes it to a binary ALU control code. It issues the code to the ALU with a start strobe and sequences single-cycle and multi-cycle operations, reporting completion and illegal commands. It sits between the switch/button command front end and the ALU datapath.

Parameters:
CTRL_W, 8, one-hot command width (>=2)
ACTRL_W, 4, ALU control code width; must be >= clog2(CTRL_W)
MC_MASK, 8'b0011_0000, CTRL_W-bit mask; a set bit marks that command bit as a multi-cycle op
MC_LAT, 4, extra busy cycles for multi-cycle ops (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd  in  CTRL_W  one-hot operation select; MSB = op 0
cmd_ready  out  1  block can accept a command
alu_ctrl  out  ACTRL_W  registered ALU control code
alu_start  out  1  one-cycle strobe: alu_ctrl is newly valid
alu_busy  out  1  operation in flight
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-command pulse
err_sticky  out  1  latched illegal-command flag
clear_err  in  1  synchronous clear of err_sticky
flush  in  1  synchronous abort to IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, alu_ctrl=0, alu_start=0, alu_busy=0, done=0, err=0, err_sticky=0, counter=0. cmd_ready=1 after reset release.
- Decode: if cmd has exactly one bit i set, code = CTRL_W-1-i, zero-extended to ACTRL_W. Examples: 8'b1000_0000 -> 0; 8'b0100_0000 -> 1; 8'b0000_0001 -> 7. A zero or multi-bit cmd is illegal.
- Handshake: accept when cmd_valid && cmd_ready at a rising edge. cmd_ready=1 only in IDLE. cmd is sampled only on accept.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE + accept of a legal cmd: alu_ctrl <= code, go to ISSUE.
- IDLE + accept of an illegal cmd: command is consumed; err=1 next cycle; err_sticky<=1; alu_ctrl unchanged; stay IDLE.
- ISSUE (1 cycle): alu_start=1, alu_busy=1. If MC_MASK[i]=1, load counter=MC_LAT-1 and go to WAIT; otherwise go to DONE.
- WAIT: alu_busy=1. Counter decrements each cycle; at 0, go to DONE.
- DONE (1 cycle): done=1, alu_busy=0, then go to IDLE.
- Timing, with accept in cycle 0: ISSUE in cycle 1. Single-cycle op: done in cycle 2, cmd_ready=1 in cycle 3. Multi-cycle op: WAIT in cycles 2..MC_LAT+1, done in cycle MC_LAT+2.
- alu_ctrl holds its value until the next legal accept; it is not cleared on done, error or flush.
- flush: in any state, at the next edge go to IDLE, counter=0, and assert no done/start. Flush in IDLE while cmd_valid=1: flush wins and the command is not accepted.
- err_sticky: a set from an illegal accept has priority over clear_err in the same cycle.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Outputs alu_start, done, err and alu_busy are registered (decoded from the state register); no combinational path from cmd to outputs. cmd_ready is decoded from state only.

Test Plan:
- Reset then cmd=8'b1000_0000, valid 1 cycle -> cycle1: alu_ctrl=0, alu_start=1; cycle2: done=1; cycle3: cmd_ready=1.
- cmd=8'b0100_0000 -> alu_ctrl=1, single-cycle timing; then cmd=8'b0000_0001 -> alu_ctrl=7.
- cmd=8'b0001_0000 (in MC_MASK), MC_LAT=4 -> alu_busy high in cycles 1-5, done in cycle 6, cmd_ready low in cycles 1-6.
- cmd=8'b0000_0000, then cmd=8'b1100_0000 -> err pulse each time, err_sticky=1, alu_ctrl unchanged, no alu_start; clear_err in the same cycle as the second illegal accept -> err_sticky stays 1; clear_err alone -> 0.
- Multi-cycle op, flush in cycle 3 -> IDLE in cycle 4, no done, cmd_ready=1; the next command completes normally.
- rst_n low during WAIT -> all outputs 0 asynchronously; after release, the first command is decoded correctly.
